// File: rtl/chromosome_loader.sv
// chromosome_loader: receives a framed chromosome over a byte stream, checks its XOR
// checksum and commits it atomically onto the flat chromosome bus.
`default_nettype none

module chromosome_loader #(
  parameter int ROW        = 1,
  parameter int COL        = 2,
  parameter int OUT        = 2,
  parameter int BITS_ELEM  = 1,
  parameter int TIMEOUT    = 50000,
  parameter int BITS_MAT   = ROW * COL * 16,
  parameter int CHROM_W    = BITS_MAT + OUT * BITS_ELEM,
  parameter int NBYTES     = (CHROM_W + 7) / 8,
  parameter logic [CHROM_W-1:0] RESET_CHROM = 34'h2_0100_1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [CHROM_W-1:0] cromossomo,
  output logic               chrom_valid,
  output logic               busy,
  output logic               load_done,
  output logic               load_err,
  output logic [7:0]         err_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int IW = $clog2(NBYTES + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [8*NBYTES-1:0]  shadow;
  logic [IW-1:0]        idx;
  logic [7:0]           checksum;
  logic [TW-1:0]        timer;

  logic sync_hit, timed_out, take, good, bad;

  always_comb begin
    state_next = state;
    sync_hit   = (state == IDLE) && rx_valid && (rx_data == SYNC);
    // Expiry takes precedence over a strobe arriving in the same cycle.
    timed_out  = (state != IDLE) && (timer == TW'(TIMEOUT - 1));
    take       = (state != IDLE) && !timed_out && rx_valid;
    good       = (state == CHECK) && take && (rx_data == checksum);
    bad        = timed_out || ((state == CHECK) && take && (rx_data != checksum));
    case (state)
      IDLE:    if (sync_hit) state_next = PAYLOAD;
      PAYLOAD: begin
        if (timed_out)                              state_next = IDLE;
        else if (take && idx == IW'(NBYTES - 1))    state_next = CHECK;
      end
      CHECK:   if (timed_out || take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cromossomo  <= RESET_CHROM;
      chrom_valid <= 1'b0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      err_count   <= 8'h00;
      shadow      <= '0;
      idx         <= '0;
      checksum    <= 8'h00;
      timer       <= '0;
    end else begin
      busy      <= (state_next != IDLE);
      load_done <= good;
      load_err  <= bad;
      if (bad && err_count != 8'hFF) err_count <= err_count + 8'h01;

      if (sync_hit) begin
        idx      <= '0;
        checksum <= 8'h00;
        timer    <= '0;
      end else if (state != IDLE && !timed_out) begin
        if (take) begin
          timer <= '0;
          if (state == PAYLOAD) begin
            shadow[{idx, 3'b000} +: 8] <= rx_data;
            checksum                   <= checksum ^ rx_data;
            idx                        <= idx + IW'(1);
          end
        end else begin
          timer <= timer + TW'(1);
        end
      end

      if (good) begin
        cromossomo  <= shadow[CHROM_W-1:0];
        chrom_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chromosome_loader.sv
// Directed self-checking bench for chromosome_loader with a short timeout.
`default_nettype none

module tb_chromosome_loader;

  localparam int CW = 34;
  localparam logic [CW-1:0] RST_VAL = 34'h2_0100_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [CW-1:0] cromossomo;
  logic          chrom_valid, busy, load_done, load_err;
  logic [7:0]    err_count;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int err_pulses = 0;

  chromosome_loader #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cromossomo(cromossomo), .chrom_valid(chrom_valid), .busy(busy),
    .load_done(load_done), .load_err(load_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done === 1'b1) done_pulses++;
    if (load_err === 1'b1) err_pulses++;
  end

  // Drive one strobe; returns 1 time unit after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [39:0] payload, input logic [7:0] chk);
    send_byte(8'hA5);
    for (int k = 0; k < 5; k++) send_byte(payload[8*k +: 8]);
    send_byte(chk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (cromossomo !== RST_VAL) begin errors++; $display("FAIL reset_chrom got=%h exp=%h", cromossomo, RST_VAL); end
    checks++; if (chrom_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got valid=%b busy=%b exp 0 0", chrom_valid, busy); end
    checks++; if (err_count !== 8'h00 || load_done !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL reset_cnt got cnt=%h done=%b err=%b exp 0", err_count, load_done, load_err); end
  endtask

  task automatic test_good_frame;
    int d0 = done_pulses;
    send_frame(40'h01_FF00_00FF, 8'h01);
    checks++; if (cromossomo !== 34'h1_FF00_00FF || load_done !== 1'b1) begin errors++; $display("FAIL good_latency got=%h done=%b exp=1ff0000ff 1", cromossomo, load_done); end
    idle(3);
    checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL good_done_once got=%0d exp=1", done_pulses - d0); end
    checks++; if (chrom_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL good_flags got valid=%b busy=%b exp 1 0", chrom_valid, busy); end
  endtask

  task automatic test_bad_checksum;
    int e0 = err_pulses;
    int d0 = done_pulses;
    send_frame(40'h00_4433_2211, 8'hFF);
    idle(3);
    checks++; if (err_pulses - e0 !== 1 || done_pulses != d0) begin errors++; $display("FAIL bad_pulses got err=%0d done=%0d exp 1 0", err_pulses - e0, done_pulses - d0); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL bad_count got=%h exp=01", err_count); end
    checks++; if (cromossomo !== 34'h1_FF00_00FF) begin errors++; $display("FAIL bad_unchanged got=%h exp=1ff0000ff", cromossomo); end
    send_frame(40'h00_4433_2211, 8'h44);
    idle(2);
    checks++; if (cromossomo !== 34'h0_4433_2211) begin errors++; $display("FAIL bad_recover got=%h exp=044332211", cromossomo); end
  endtask

  task automatic test_noise_and_sync_data;
    send_byte(8'h00); send_byte(8'h5A); send_byte(8'h13);
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_idle got busy=%b exp 0", busy); end
    send_frame(40'h02_005A_3CA5, 8'hC1);
    idle(2);
    checks++; if (cromossomo !== 34'h2_005A_3CA5) begin errors++; $display("FAIL noise_frame got=%h exp=2005a3ca5", cromossomo); end
  endtask

  task automatic test_back_to_back;
    int d0 = done_pulses;
    send_frame(40'hAB_1234_5678, 8'hA3);
    checks++; if (cromossomo !== 34'h3_1234_5678) begin errors++; $display("FAIL b2b_first got=%h exp=312345678", cromossomo); end
    send_frame(40'h00_0F0F_F0F0, 8'h00);
    idle(3);
    checks++; if (cromossomo !== 34'h0_0F0F_F0F0) begin errors++; $display("FAIL b2b_second got=%h exp=00f0ff0f0", cromossomo); end
    checks++; if (done_pulses - d0 !== 2) begin errors++; $display("FAIL b2b_done got=%0d exp=2", done_pulses - d0); end
  endtask

  task automatic test_timeout;
    int d0 = done_pulses;
    send_byte(8'hA5);
    send_byte(8'h12);
    rx_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (load_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early got err=%b busy=%b exp 0 1", load_err, busy); end
    @(posedge clk); #1;
    checks++; if (load_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_fire got err=%b busy=%b exp 1 0", load_err, busy); end
    idle(2);
    checks++; if (err_count !== 8'h02 || cromossomo !== 34'h0_0F0F_F0F0 || done_pulses != d0) begin errors++; $display("FAIL timeout_nocommit got cnt=%h chrom=%h exp 02 00f0ff0f0", err_count, cromossomo); end
  endtask

  task automatic test_reset_midframe_and_saturate;
    int e0 = err_pulses;
    int d0 = done_pulses;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    checks++; if (cromossomo !== RST_VAL || chrom_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got=%h v=%b b=%b exp=%h 0 0", cromossomo, chrom_valid, busy, RST_VAL); end
    checks++; if (err_pulses != e0 || done_pulses != d0 || err_count !== 8'h00) begin errors++; $display("FAIL midrst_pulses got err=%0d done=%0d cnt=%h exp 0 0 00", err_pulses - e0, done_pulses - d0, err_count); end
    for (int n = 0; n < 255; n++) send_frame(40'h00_0000_0001, 8'h00);
    idle(2);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_255 got=%h exp=ff", err_count); end
    send_frame(40'h00_0000_0001, 8'h00);
    idle(2);
    checks++; if (err_count !== 8'hFF || cromossomo !== RST_VAL) begin errors++; $display("FAIL sat_256 got cnt=%h chrom=%h exp ff %h", err_count, cromossomo, RST_VAL); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_noise_and_sync_data();
    test_back_to_back();
    test_timeout();
    test_reset_midframe_and_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
